// File: rtl/register_file_sb.sv
// General-purpose register file: two combinational read ports, one write port,
// optional write-to-read forwarding, optional zero register 0, busy scoreboard.
module register_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              waw_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              rsv_ok;
  logic              waw_hit;

  assign wr_ok  = we  && !(R0_ZERO != 0 && wa == '0);
  assign rsv_ok = rsv && !(R0_ZERO != 0 && rsv_addr == '0);
  // A writeback clearing the same register this cycle makes the re-reserve legal.
  assign waw_hit = rsv_ok && busy[rsv_addr] && !(wr_ok && wa == rsv_addr);

  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[wa]       = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + (ADDR_W+1)'(v[i]);
    return n;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      waw_err  <= 1'b0;
    end else begin
      if (wr_ok) regs[wa] <= wd;
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
      if (waw_hit) waw_err <= 1'b1;
    end
  end

  always_comb begin
    ra_data = regs[ra_addr];
    ra_busy = busy[ra_addr];
    if (BYPASS != 0 && wr_ok && wa == ra_addr) begin
      ra_data = wd;
      ra_busy = rsv_ok && rsv_addr == wa;
    end
    if (R0_ZERO != 0 && ra_addr == '0) begin
      ra_data = '0;
      ra_busy = 1'b0;
    end
  end

  always_comb begin
    rb_data = regs[rb_addr];
    rb_busy = busy[rb_addr];
    if (BYPASS != 0 && wr_ok && wa == rb_addr) begin
      rb_data = wd;
      rb_busy = rsv_ok && rsv_addr == wa;
    end
    if (R0_ZERO != 0 && rb_addr == '0) begin
      rb_data = '0;
      rb_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: two instances (forwarding/no zero reg,
// and no forwarding/zero reg) driven with identical directed + random stimulus.
module tb_register_file_sb;

  typedef struct packed {
    logic [15:0] ra_d;
    logic [15:0] rb_d;
    logic        ra_b;
    logic        rb_b;
    logic [3:0]  cnt;
    logic        waw;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [2:0]  ra_addr, rb_addr, wa, rsv_addr;
  logic [15:0] wd;
  logic        we, rsv;

  logic [15:0] a_ra_data, a_rb_data, b_ra_data, b_rb_data;
  logic        a_ra_busy, a_rb_busy, b_ra_busy, b_rb_busy;
  logic [3:0]  a_busy_cnt, b_busy_cnt;
  logic        a_waw_err, b_waw_err;

  int tests = 0;
  int fails = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Reference state: plain arrays, one set per instance
  logic [15:0] mem [2][8];
  bit          bsy [2][8];
  bit          wawm[2];
  int          zr  [2] = '{0, 1};
  int          byp [2] = '{1, 0};
  bit          model_ok = 0;

  register_file_sb #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(0), .BYPASS(1)) u_a (
    .clock(clock), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(a_ra_data), .rb_data(a_rb_data), .ra_busy(a_ra_busy), .rb_busy(a_rb_busy),
    .we(we), .wa(wa), .wd(wd), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy_cnt(a_busy_cnt), .waw_err(a_waw_err));

  register_file_sb #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1), .BYPASS(0)) u_b (
    .clock(clock), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(b_ra_data), .rb_data(b_rb_data), .ra_busy(b_ra_busy), .rb_busy(b_rb_busy),
    .we(we), .wa(wa), .wd(wd), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy_cnt(b_busy_cnt), .waw_err(b_waw_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit is_zero(int k, logic [2:0] a);
    return zr[k] != 0 && a == 3'd0;
  endfunction

  function automatic void model_read(int k, logic [2:0] a, output logic [15:0] d, output logic b);
    if (is_zero(k, a)) begin
      d = 16'h0; b = 1'b0;
    end else if (byp[k] != 0 && we && wa == a) begin
      d = wd; b = rsv && rsv_addr == a;
    end else begin
      d = mem[k][a]; b = bsy[k][a];
    end
  endfunction

  function automatic exp_t predict(int k);
    exp_t e;
    int   n = 0;
    model_read(k, ra_addr, e.ra_d, e.ra_b);
    model_read(k, rb_addr, e.rb_d, e.rb_b);
    for (int i = 0; i < 8; i++) n += int'(bsy[k][i]);
    e.cnt = 4'(n);
    e.waw = wawm[k];
    return e;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) begin mem[k][i] = 16'h0; bsy[k][i] = 0; end
        wawm[k] = 0;
      end else begin
        bit wr_live = we && !is_zero(k, wa);
        bit was_busy = bsy[k][rsv_addr];
        if (wr_live) begin mem[k][wa] = wd; bsy[k][wa] = 0; end
        if (rsv && !is_zero(k, rsv_addr)) begin
          if (was_busy && !(wr_live && wa == rsv_addr)) wawm[k] = 1;
          bsy[k][rsv_addr] = 1;
        end
      end
    end
  endtask

  task automatic step(bit r, bit w, logic [2:0] a, logic [15:0] d,
                      bit rv, logic [2:0] radr, logic [2:0] ra, logic [2:0] rb);
    reset = r; we = w; wa = a; wd = d; rsv = rv; rsv_addr = radr;
    ra_addr = ra; rb_addr = rb;
    if (model_ok) begin
      qa.push_back(predict(0));
      qb.push_back(predict(1));
    end
    @(posedge clock);
    #1;
    model_edge();
    if (r) model_ok = 1;
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("A ra_data",  32'(a_ra_data),  32'(e.ra_d));
        cmp("A rb_data",  32'(a_rb_data),  32'(e.rb_d));
        cmp("A ra_busy",  32'(a_ra_busy),  32'(e.ra_b));
        cmp("A rb_busy",  32'(a_rb_busy),  32'(e.rb_b));
        cmp("A busy_cnt", 32'(a_busy_cnt), 32'(e.cnt));
        cmp("A waw_err",  32'(a_waw_err),  32'(e.waw));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("B ra_data",  32'(b_ra_data),  32'(e.ra_d));
        cmp("B rb_data",  32'(b_rb_data),  32'(e.rb_d));
        cmp("B ra_busy",  32'(b_ra_busy),  32'(e.ra_b));
        cmp("B rb_busy",  32'(b_rb_busy),  32'(e.rb_b));
        cmp("B busy_cnt", 32'(b_busy_cnt), 32'(e.cnt));
        cmp("B waw_err",  32'(b_waw_err),  32'(e.waw));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; rsv = 1'b0; rsv_addr = '0;
    ra_addr = '0; rb_addr = '0;
    step(1, 0, 0, 16'h0, 0, 0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0, 3, 5);
    // Basic writes then reads
    step(0, 1, 3, 16'h1234, 0, 0, 3, 5);
    step(0, 1, 5, 16'hBEEF, 0, 0, 3, 5);
    step(0, 0, 0, 16'h0,    0, 0, 3, 5);
    // Same-cycle write and read of r2
    step(0, 1, 2, 16'h00AA, 0, 0, 2, 2);
    step(0, 0, 0, 16'h0,    0, 0, 2, 2);
    // Reserve, double reserve (WAW), writeback
    step(0, 0, 0, 16'h0,    1, 4, 4, 3);
    step(0, 0, 0, 16'h0,    1, 4, 4, 4);
    step(0, 1, 4, 16'h4444, 0, 0, 4, 4);
    step(0, 0, 0, 16'h0,    0, 0, 4, 4);
    // Write and reserve the same free register together
    step(0, 1, 6, 16'h5A5A, 1, 6, 6, 6);
    step(0, 0, 0, 16'h0,    0, 0, 6, 6);
    // Register 0 write/reserve
    step(0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    step(0, 0, 0, 16'h0,    0, 0, 0, 0);
    // Fill reservations, then reset with a write pending
    for (int i = 1; i < 8; i++) step(0, 0, 0, 16'h0, 1, 3'(i), 3'(i), 3'(i - 1));
    step(0, 0, 0, 16'h0,    0, 0, 1, 7);
    step(1, 1, 3, 16'h7777, 0, 0, 3, 1);
    step(0, 0, 0, 16'h0,    0, 0, 3, 1);
    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0] a, ra, rb, ad;
      a  = 3'($urandom_range(0, 7));
      ad = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 2) == 0) ? ra : 3'($urandom_range(0, 7));
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, a,
           16'($urandom), $urandom_range(0, 9) < 3, ad, ra, rb);
    end
    @(negedge clock);
    @(negedge clock);
    cmp("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
